fifo_sync: RTL and testbench

Single-clock, first-in-first-out data buffer with parameterised data width and depth. It decouples a producer and a consumer running on the same clock. Writes and reads use independent enable strobes, and full/empty status flags guard them. Protocol violations (write when full, read when empty) are ignored and flagged, so upstream and downstream logic can be debugged without corrupting stored data.

---
 rtl/fifo_sync.sv | 113 +++++++++++
 tb/tb_fifo_sync.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered data output, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests.
module fifo_sync #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync: depth must be a power of two and at least 2");
  end

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] dout_q, dout_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Acceptance is judged on the flags as they stand before the edge; reset wins.
  assign wr_ok_s = wr_en & ~full_q & ~rst;
  assign rd_ok_s = rd_en & ~empty_q & ~rst;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (wr_ok_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_ok_s) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem_q[rptr_q];
    end else begin
      rptr_d = rptr_q;
      dout_d = dout_q;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d   = wr_en & full_q;
    unf_d   = rd_en & empty_q;
    full_d  = (count_d == CW'(depth));
    empty_d = (count_d == CW'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= AW'(0);
      rptr_q  <= AW'(0);
      count_q <= CW'(0);
      dout_q  <= width'(0);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout      = dout_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fifo_sync;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         full;
  logic         empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  fifo_sync #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive requests, let the edge happen, advance model, compare.
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    bit was_full, was_empty;
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    #1;
    was_full  = (model_q.size() == D);
    was_empty = (model_q.size() == 0);
    if (r) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_ovf = w && was_full;
      m_unf = rd && was_empty;
      if (rd && !was_empty) m_dout = model_q.pop_front();
      if (w && !was_full) model_q.push_back(d);
    end
    chk("dout", 32'(dout), 32'(m_dout));
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", 32'(full), 32'(model_q.size() == D));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);

    // Fill with 0..15, then drain in order.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_seq", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Overflow on a full FIFO must not disturb contents.
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("ovf_drain", 32'(dout), 32'(i));
    end

    // Underflow on an empty FIFO holds dout.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_dout", 32'(dout), 32'd15);
    chk("unf_count", 32'(count), 32'd0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(i + 100));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("wrap_seq", 32'(dout), 32'(8'h20 + i));
    end

    // Simultaneous requests with 5 entries.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
      chk("both_count", 32'(count), 32'd5);
      chk("both_dout", 32'(dout), 32'(8'h50 + i));
    end
    // Full with both requests: only the read goes through.
    while (model_q.size() < D) step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("full_both_count", 32'(count), 32'd15);
    chk("full_both_ovf", 32'(overflow), 32'd1);
    // Empty with both requests: only the write goes through.
    while (model_q.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h33);
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_unf", 32'(underflow), 32'd1);

    // Reset mid-operation with requests pending.
    step(1'b0, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b1, 1'b1, 8'h03);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Random traffic, occasionally resetting.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
